cryptoveril_decrypt: RTL and testbench

//  Receive-side inverse of the cryptoveril 16-bit cipher: recovers plaintext from ciphertext using the same 5-bit key.

---
 rtl/cryptoveril_decrypt.sv | 81 ++++++++
 tb/tb_cryptoveril_decrypt.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/cryptoveril_decrypt.sv
// cryptoveril_decrypt: three-stage inverse cipher (D3 rotate-right, D2 subtract, D1 xor) behind an ld/start handshake.
// Define CRYPTOVERIL_DEC_KEYLOCK_EN to latch key_bits at load; otherwise the live key feeds every stage.
module cryptoveril_decrypt (
    input  logic        clk1,
    input  logic        rst,
    input  logic [15:0] input_data,
    input  logic [4:0]  key_bits,
    input  logic        ld,
    input  logic        start,
    output logic [15:0] output_data,
    output logic        done,
    output logic        busy,
    output logic        borrow
);
    typedef enum logic [2:0] {IDLE, LOADED, D3, D2, D1, DONE} state_t;
    state_t state_q, state_d;
    logic [15:0] data_q, data_d, stg3_q, stg3_d, out_q, out_d;
    logic [16:0] stg2_q, stg2_d;
    logic done_q, done_d, busy_q, busy_d, borrow_q, borrow_d;
    logic [4:0] key;
    logic [3:0] rot;
    logic [15:0] k16;
    logic accept;
`ifdef CRYPTOVERIL_DEC_KEYLOCK_EN
    logic [4:0] key_q, key_d;
    assign key = key_q;
`else
    assign key = key_bits;
`endif
    always_comb begin
        accept = ld && (state_q == IDLE || state_q == DONE);
        rot = key[3:0];
        k16 = {key[0], key, key, key};
        data_d = accept ? input_data : data_q;
        stg3_d = state_q == D3 ? (data_q >> rot) | (data_q << (5'd16 - {1'b0, rot})) : stg3_q;
        stg2_d = state_q == D2 ? {1'b0, stg3_q} - {1'b0, k16} : stg2_q;
        out_d = state_q == D1 ? stg2_q[15:0] ^ k16 : out_q;
        borrow_d = state_q == D1 ? stg2_q[16] : borrow_q;
        state_d = accept ? LOADED :
                  state_q == LOADED ? (start ? D3 : LOADED) :
                  state_q == D3 ? D2 :
                  state_q == D2 ? D1 :
                  state_q == D1 ? DONE : IDLE;
        done_d = state_d == DONE;
        busy_d = state_d == LOADED || state_d == D3 || state_d == D2 || state_d == D1;
`ifdef CRYPTOVERIL_DEC_KEYLOCK_EN
        key_d = accept ? key_bits : key_q;
`endif
    end
    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q <= IDLE;
            data_q <= '0;
            stg3_q <= '0;
            stg2_q <= '0;
            out_q <= '0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
            borrow_q <= 1'b0;
`ifdef CRYPTOVERIL_DEC_KEYLOCK_EN
            key_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            data_q <= data_d;
            stg3_q <= stg3_d;
            stg2_q <= stg2_d;
            out_q <= out_d;
            done_q <= done_d;
            busy_q <= busy_d;
            borrow_q <= borrow_d;
`ifdef CRYPTOVERIL_DEC_KEYLOCK_EN
            key_q <= key_d;
`endif
        end
    end
    assign output_data = out_q;
    assign done = done_q;
    assign busy = busy_q;
    assign borrow = borrow_q;
endmodule

// File: tb/tb_cryptoveril_decrypt.sv
// tb_cryptoveril_decrypt: directed bench with a result scoreboard for cryptoveril_decrypt.
module tb_cryptoveril_decrypt;
    logic clk1 = 1'b0, rst = 1'b1, ld = 1'b0, start = 1'b0;
    logic [15:0] input_data = '0;
    logic [4:0] key_bits = '0;
    logic [15:0] output_data;
    logic done, busy, borrow;
    int n_cmp = 0, n_err = 0;
    logic [16:0] sb[$];
    logic [16:0] mon_exp;
    logic [15:0] rnd_d;
    logic [4:0] rnd_k;

    always #5 clk1 = ~clk1;

    cryptoveril_decrypt dut (
        .clk1(clk1), .rst(rst), .input_data(input_data), .key_bits(key_bits),
        .ld(ld), .start(start), .output_data(output_data), .done(done),
        .busy(busy), .borrow(borrow)
    );

    function automatic logic [16:0] model(input logic [15:0] c, input logic [4:0] k);
        logic [15:0] k16, r;
        logic [16:0] d;
        k16 = {k[0], k, k, k};
        for (int i = 0; i < 16; i++) r[i] = c[(i + int'(k[3:0])) % 16];
        d = {1'b0, r} - {1'b0, k16};
        return {d[16], d[15:0] ^ k16};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [15:0] d, input logic [4:0] k, input logic s, input logic [16:0] e);
        input_data = d;
        key_bits = k;
        start = s;
        ld = 1'b1;
        sb.push_back(e);
        @(negedge clk1);
        ld = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!done && k < 20) begin
            @(negedge clk1);
            k++;
        end
        check({tag, "_timeout"}, {31'b0, done}, 32'd1);
    endtask

    always @(negedge clk1) begin
        if (done) begin
            if (sb.size() == 0) check("unexpected_done", 32'd1, 32'd0);
            else begin
                mon_exp = sb.pop_front();
                check("output_data", {16'b0, output_data}, {16'b0, mon_exp[15:0]});
                check("borrow", {31'b0, borrow}, {31'b0, mon_exp[16]});
            end
        end
    end

    initial begin
        repeat (10) @(negedge clk1);
        rst = 1'b0;
        check("rst_out", {16'b0, output_data}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_borrow", {31'b0, borrow}, 32'd0);
        @(negedge clk1);
        load(16'h0001, 5'b00110, 1'b1, {1'b1, 16'hF3FC});
        check("lat_busy0", {31'b0, busy}, 32'd1);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk1);
            check($sformatf("lat_done%0d", k), {31'b0, done}, {31'b0, k == 4});
            check($sformatf("lat_busy%0d", k), {31'b0, busy}, {31'b0, k < 4});
        end
        start = 1'b0;
        repeat (3) @(negedge clk1);
        check("hold_out", {16'b0, output_data}, 32'h0000F3FC);
        check("idle_busy", {31'b0, busy}, 32'd0);
        load(16'hBEEF, 5'b00000, 1'b1, {1'b0, 16'hBEEF});
        wait_done("zero_key");
        @(negedge clk1);
        start = 1'b0;
        load(16'h0001, 5'b00110, 1'b0, {1'b1, 16'hF3FC});
        for (int k = 0; k < 5; k++) begin
            input_data = 16'h1234;
            ld = (k == 2);
            check("wait_busy", {31'b0, busy}, 32'd1);
            check("wait_done", {31'b0, done}, 32'd0);
            @(negedge clk1);
        end
        ld = 1'b0;
        start = 1'b1;
        wait_done("late_start");
        @(negedge clk1);
        load(16'h0001, 5'b00110, 1'b1, 17'h0);
        repeat (2) @(negedge clk1);
        check("mid_busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        void'(sb.pop_back());
        @(negedge clk1);
        rst = 1'b0;
        check("abort_out", {16'b0, output_data}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_borrow", {31'b0, borrow}, 32'd0);
        repeat (3) begin
            @(negedge clk1);
            check("abort_nodone", {31'b0, done}, 32'd0);
        end
        load(16'hA5C3, 5'b10111, 1'b1, model(16'hA5C3, 5'b10111));
        wait_done("reload");
        @(negedge clk1);
        load(16'h0001, 5'b00110, 1'b1, {1'b1, 16'hF3FC});
`ifdef CRYPTOVERIL_DEC_KEYLOCK_EN
        @(negedge clk1);
        key_bits = 5'b11111;
`endif
        wait_done("keylock");
        for (int i = 0; i < 6; i++) begin
            rnd_d = 16'($urandom);
            rnd_k = 5'($urandom);
            load(rnd_d, rnd_k, 1'b1, model(rnd_d, rnd_k));
            wait_done($sformatf("rand%0d", i));
        end
        @(negedge clk1);
        start = 1'b0;
        repeat (2) @(negedge clk1);
        check("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
